mux_nx1_stream: RTL and testbench
=================================

Name: mux_nx1_stream

Overview:
- Parametrised N-channel, DW-bit multiplexer with a valid/ready handshake on every input and on the output, plus one registered output stage.
- Two run-time modes:
  - FIXED: the channel is chosen by a select input.
  - ROUND_ROBIN: the next valid channel is chosen fairly.
- Successor to the combinational 2:1/4:1 muxes, for datapaths that need backpressure and arbitration.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16.
- DW, 8, data width per channel in bits.
- SW, $clog2(N_CH), select/channel-index width; derived, not to be overridden.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- mode  in  1  0 = FIXED, 1 = ROUND_ROBIN.
- sel  in  SW  channel select, used in FIXED mode only.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*DW  channel i occupies bits [i*DW +: DW].
- in_ready  out  N_CH  per-channel ready; one-hot or zero.
- out_valid  out  1  output register holds data.
- out_data  out  DW  registered data.
- out_ch  out  SW  index of the channel that produced out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready is forced to 0 while in reset.
  - Reset asserted mid-transfer drops any held word; no partial state survives.
- load_en = ~out_valid | out_ready. The output register accepts a new word only when it is empty or being drained in the same cycle.
- Grant, combinational, evaluated each cycle:
  - FIXED: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant. An out-of-range sel is never granted.
  - ROUND_ROBIN: grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... with wrap modulo N_CH. No valid channel means no grant.
- in_ready[i] = load_en & grant_valid & (grant == i). At most one bit is high. Combinational path out_ready -> in_ready is permitted and documented.
- Transfer on channel i when in_valid[i] & in_ready[i]. Next edge: out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- If out_valid & out_ready with no input transfer: out_valid <= 0 next edge. out_data and out_ch hold their last values.
- While out_valid & ~out_ready: out_data and out_ch are stable and all in_ready are 0.
- Latency: input transfer to out_valid is 1 cycle. Throughput is 1 word/cycle with out_ready held high.
- rr_ptr update:
  - On each transfer, in either mode, rr_ptr <= grant+1, wrapping from N_CH-1 to 0.
  - With no transfer, rr_ptr holds.
- Fairness: in ROUND_ROBIN with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N_CH-1,0,...
- A mode or sel change takes effect on the same cycle's grant and never alters a word already in the output register.
- in_valid may drop without a handshake; the block does not check protocol on inputs.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1;
  - clog2 helper function;
  - N_CH range limits.
- Sub-module rr_arbiter:
  - parameters N_CH and SW;
  - inputs req[N_CH] and ptr[SW];
  - outputs gnt_valid and gnt_idx[SW];
  - purely combinational rotate-priority search.
- mux_nx1_stream instantiates rr_arbiter and contains the mode mux, output register and rr_ptr.

Test Plan:
- Reset: hold rst_n=0 with in_valid=all-ones -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release -> first word appears 1 cycle after the first transfer.
- FIXED, N_CH=4, DW=8, sel=2, in_data ch2=0xA5, all valid, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_ch=2. Set sel=3 -> only ch3 granted. Set sel=2 with in_valid[2]=0 -> no grant, out_valid falls after drain.
- ROUND_ROBIN, all 4 valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1010 -> sequence alternates 1,3 in fairness order from the current rr_ptr.
- Backpressure: out_ready=0 for 3 cycles while holding 0x3C -> out_data=0x3C is stable, in_ready=0. Raise out_ready -> same-cycle refill, no bubble, no lost or duplicated word (scoreboard per channel).
- Mode switch mid-stream: in RR with rr_ptr=2, switch to FIXED sel=0 -> the held word is unchanged, the next grant is ch0 and rr_ptr becomes 1. Switch back to RR -> the search starts at ch1.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> outputs clear immediately without a clock edge, and rr_ptr=0 after release.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 streaming multiplexer.
// Mode encodings, supported channel-count range and a constant-foldable ceil(log2).
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int N_CH_MIN = 2;
   localparam int N_CH_MAX = 16;

   // Smallest r with 2**r >= n; usable in parameter defaults.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester found
// starting at ptr and wrapping modulo N_CH.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int SW   = clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [SW-1:0]   ptr,
   output logic            gnt_valid,
   output logic [SW-1:0]   gnt_idx
);

   int idx;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_CH;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SW'(idx);
         end
      end
   end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin grant
// and a single registered output stage; in_ready depends combinationally on out_ready.
module mux_nx1_stream
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int DW   = 8,
   parameter int SW   = clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [SW-1:0]    sel,
   input  logic [N_CH-1:0]  in_valid,
   input  logic [N_CH*DW-1:0] in_data,
   output logic [N_CH-1:0]  in_ready,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic [SW-1:0]    out_ch,
   input  logic             out_ready
);

   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q,  out_data_d;
   logic [SW-1:0]   out_ch_q,    out_ch_d;
   logic [SW-1:0]   rr_ptr_q,    rr_ptr_d;

   logic [N_CH-1:0] fix_req;
   logic            fix_valid;
   logic            rr_valid;
   logic [SW-1:0]   rr_idx;
   logic            grant_valid;
   logic [SW-1:0]   grant_idx;
   logic            load_en;
   logic            xfer;

   rr_arbiter #(
      .N_CH (N_CH),
      .SW   (SW)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // An out-of-range sel matches no channel, so it can never be granted.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_fix
      assign fix_req[gi] = in_valid[gi] & (sel == SW'(gi));
   end
   assign fix_valid = |fix_req;

   assign grant_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
   assign grant_idx   = (mode == MODE_RR) ? rr_idx   : sel;

   assign load_en = ~out_valid_q | out_ready;
   assign xfer    = rst_n & load_en & grant_valid;

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_rdy
      assign in_ready[gi] = xfer & (grant_idx == SW'(gi));
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[grant_idx*DW +: DW];
         out_ch_d    = grant_idx;
         rr_ptr_d    = (grant_idx == SW'(N_CH - 1)) ? '0 : grant_idx + SW'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed self-checking bench for mux_nx1_stream (N_CH=4, DW=8): reset, fixed,
// round-robin, backpressure, mode switch and asynchronous reset scenarios.
module tb_mux_nx1_stream;

   localparam int N_CH = 4;
   localparam int DW   = 8;
   localparam int SW   = 2;

   logic            clk;
   logic            rst_n;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N_CH-1:0] in_valid;
   logic [N_CH*DW-1:0] in_data;
   logic [N_CH-1:0] in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_ch;
   logic            out_ready;

   int checks;
   int failures;

   logic [DW-1:0] ch_val [N_CH];

   mux_nx1_stream #(.N_CH(N_CH), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL release_in_ready got=%b exp=0001", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
         failures++; $display("FAIL release_first_word got=v%0b d%h c%0d exp=v1 d11 c0", out_valid, out_data, out_ch); end
      $display("reset: done, first word ch0 data=%h", out_data);
   endtask

   task automatic test_fixed;
      mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_sel2_ready got=%b exp=0100", in_ready); end
      tick();
      checks++; if (out_data !== 8'hA5 || out_ch !== 2'd2) begin
         failures++; $display("FAIL fixed_sel2_word got=d%h c%0d exp=dA5 c2", out_data, out_ch); end
      $display("fixed: sel=2 -> data=%h ch=%0d", out_data, out_ch);
      sel = 2'd3;
      #1;
      checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL fixed_sel3_ready got=%b exp=1000", in_ready); end
      tick();
      checks++; if (out_data !== 8'h3C || out_ch !== 2'd3) begin
         failures++; $display("FAIL fixed_sel3_word got=d%h c%0d exp=d3C c3", out_data, out_ch); end
      $display("fixed: sel=3 -> data=%h ch=%0d", out_data, out_ch);
      sel = 2'd2; in_valid = 4'b1011;
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_nogrant_ready got=%b exp=0000", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== 8'h3C || out_ch !== 2'd3) begin
         failures++; $display("FAIL fixed_drain got=v%0b d%h c%0d exp=v0 d3C c3", out_valid, out_data, out_ch); end
      $display("fixed: sel=2 invalid -> drained out_valid=%0b", out_valid);
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      logic [1:0] exp_ch;
      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_ch = 2'(k % 4);
         exp_rdy = 4'b0001 << exp_ch;
         #1;
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_all_ready k=%0d got=%b exp=%b", k, in_ready, exp_rdy); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== ch_val[exp_ch]) begin
            failures++; $display("FAIL rr_all_word k=%0d got=v%0b c%0d d%h exp=v1 c%0d d%h", k, out_valid, out_ch, out_data, exp_ch, ch_val[exp_ch]); end
         $display("rr all-valid: k=%0d ch=%0d data=%h", k, out_ch, out_data);
      end
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
         tick();
         checks++; if (out_ch !== exp_ch || out_data !== ch_val[exp_ch]) begin
            failures++; $display("FAIL rr_1010_word k=%0d got=c%0d d%h exp=c%0d d%h", k, out_ch, out_data, exp_ch, ch_val[exp_ch]); end
         $display("rr 1010: k=%0d ch=%0d data=%h", k, out_ch, out_data);
      end
   endtask

   task automatic test_backpressure;
      int delivered [N_CH];
      int accepted [N_CH];
      logic [1:0] exp_ch;
      for (int i = 0; i < N_CH; i++) begin delivered[i] = 0; accepted[i] = 0; end
      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready k=%0d got=%b exp=0000", k, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd3) begin
            failures++; $display("FAIL bp_stall_hold k=%0d got=v%0b d%h c%0d exp=v1 d3C c3", k, out_valid, out_data, out_ch); end
         $display("backpressure: stall k=%0d data=%h", k, out_data);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_ch = 2'(k);
         #1;
         if (out_valid && out_ready) delivered[out_ch]++;
         for (int i = 0; i < N_CH; i++) if (in_valid[i] && in_ready[i]) accepted[i]++;
         tick();
         checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== ch_val[exp_ch]) begin
            failures++; $display("FAIL bp_refill k=%0d got=v%0b c%0d d%h exp=v1 c%0d d%h", k, out_valid, out_ch, out_data, exp_ch, ch_val[exp_ch]); end
         $display("backpressure: refill k=%0d ch=%0d data=%h", k, out_ch, out_data);
      end
      for (int i = 0; i < N_CH; i++) begin
         checks++; if (delivered[i] != 1 || accepted[i] != 1) begin
            failures++; $display("FAIL bp_scoreboard ch=%0d got=delivered%0d accepted%0d exp=1 1", i, delivered[i], accepted[i]); end
      end
   endtask

   task automatic test_mode_switch;
      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_ch !== 2'd1 || out_data !== 8'h22) begin
         failures++; $display("FAIL ms_setup got=c%0d d%h exp=c1 d22", out_ch, out_data); end
      out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL ms_stall_ready got=%b exp=0000", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) begin
         failures++; $display("FAIL ms_held_word got=v%0b c%0d d%h exp=v1 c1 d22", out_valid, out_ch, out_data); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL ms_fixed_ready got=%b exp=0001", in_ready); end
      tick();
      checks++; if (out_ch !== 2'd0 || out_data !== 8'h11) begin
         failures++; $display("FAIL ms_fixed_word got=c%0d d%h exp=c0 d11", out_ch, out_data); end
      mode = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL ms_rr_resume_ready got=%b exp=0010", in_ready); end
      tick();
      checks++; if (out_ch !== 2'd1 || out_data !== 8'h22) begin
         failures++; $display("FAIL ms_rr_resume_word got=c%0d d%h exp=c1 d22", out_ch, out_data); end
      $display("mode switch: resumed rr at ch=%0d", out_ch);
   endtask

   task automatic test_async_reset;
      mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
         failures++; $display("FAIL async_clear got=v%0b d%h c%0d exp=v0 d00 c0", out_valid, out_data, out_ch); end
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL async_in_ready got=%b exp=0000", in_ready); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL async_ptr_ready got=%b exp=0001", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
         failures++; $display("FAIL async_first_word got=v%0b c%0d d%h exp=v1 c0 d11", out_valid, out_ch, out_data); end
      $display("async reset: restart ch=%0d data=%h", out_ch, out_data);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'hA5; ch_val[3] = 8'h3C;
      in_data = {8'h3C, 8'hA5, 8'h22, 8'h11};
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
      test_reset();
      test_fixed();
      test_round_robin();
      test_backpressure();
      test_mode_switch();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
